// File: rtl/oam_dma.sv
`default_nettype none
// ============================================================================
//  Module   : oam_dma
//  Purpose  : Sprite-attribute (OAM) DMA engine with CPU bus arbitration.
//             A CPU write to the DMA register at 0xFF46 starts a transfer.
//             The transfer copies DMA_LEN bytes from {src_hi, 8'h00} upward
//             into OAM indices 0..DMA_LEN-1, one byte per M-cycle (4 clocks).
//             While the copy owns the main bus, CPU accesses below 0xFF00
//             are blocked: writes are dropped and reads return 0xFF.
//             CPU accesses in the high region 0xFF00-0xFFFF (except 0xFF46)
//             always pass through to the io_* port.
//
//  Ports    : clk, reset        clock, synchronous active-high reset
//             cpu_*             CPU-side bus (address/enable/write/data)
//             bus_*             main bus, 0x0000-0xFEFF region
//             io_*              high region, 0xFF00-0xFFFF
//             oam_*             OAM write port (index, strobe, data)
//             dma_active        high while the DMA owns the main bus
//
//  Revision : 1.0  initial release
// ============================================================================
module oam_dma #(
  parameter int DMA_LEN = 160
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_enable,
  input  logic        cpu_write,
  input  logic [7:0]  cpu_data_out,
  output logic [7:0]  cpu_data_in,
  output logic [15:0] bus_addr,
  output logic        bus_enable,
  output logic        bus_write,
  output logic [7:0]  bus_data_out,
  input  logic [7:0]  bus_data_in,
  output logic [15:0] io_addr,
  output logic        io_enable,
  output logic        io_write,
  output logic [7:0]  io_data_out,
  input  logic [7:0]  io_data_in,
  output logic [7:0]  oam_addr,
  output logic        oam_write,
  output logic [7:0]  oam_data,
  output logic        dma_active
);

  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  localparam logic [15:0] IO_BASE      = 16'hFF00;
  localparam logic [7:0]  LAST_IDX     = 8'(DMA_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_START  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  state_t     state;
  logic [1:0] tcnt;     // T-cycle phase, in lock-step with the CPU
  logic [7:0] idx;      // byte index within the current transfer
  logic [7:0] src_hi;   // source page, echo-RAM folded
  logic [7:0] dma_reg;  // value last written to 0xFF46, unfolded

  logic t3;
  logic is_dma_reg;
  logic is_high;
  logic dma_reg_wr;
  logic active;

  assign t3         = (tcnt == 2'd3);
  assign is_dma_reg = (cpu_addr == DMA_REG_ADDR);
  assign is_high    = (cpu_addr >= IO_BASE);
  assign dma_reg_wr = cpu_enable && cpu_write && is_dma_reg;

  // Gated by reset so that the bus is released in the very cycle reset
  // is raised, not one edge later.
  assign active     = (state == ST_ACTIVE) && !reset;
  assign dma_active = active;

  // Pages 0xE0-0xFF mirror 0xC0-0xDF (echo RAM).
  function automatic logic [7:0] fold_src(input logic [7:0] v);
    return (v >= 8'hE0) ? (v & 8'hDF) : v;
  endfunction

  // --------------------------------------------------------------------------
  // Phase counter and transfer FSM. All state changes happen at the end of
  // T3. A write to 0xFF46 wins over the normal progression in any state, so a
  // rewrite mid-transfer restarts cleanly from byte 0 of the new page.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt    <= 2'd0;
      state   <= ST_IDLE;
      idx     <= 8'd0;
      src_hi  <= 8'd0;
      dma_reg <= 8'd0;
    end else begin
      tcnt <= tcnt + 2'd1;
      if (t3) begin
        if (dma_reg_wr) begin
          dma_reg <= cpu_data_out;
          src_hi  <= fold_src(cpu_data_out);
          idx     <= 8'd0;
          state   <= ST_START;
        end else begin
          case (state)
            ST_START: begin
              // One M-cycle of setup during which the CPU still owns the bus.
              idx   <= 8'd0;
              state <= ST_ACTIVE;
            end
            ST_ACTIVE: begin
              if (idx == LAST_IDX) begin
                idx   <= 8'd0;
                state <= ST_IDLE;
              end else begin
                idx <= idx + 8'd1;
              end
            end
            default: begin
              state <= ST_IDLE;
            end
          endcase
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // High-region routing. 0xFF46 is serviced locally and never reaches io_*.
  // --------------------------------------------------------------------------
  always_comb begin
    io_addr     = 16'h0000;
    io_enable   = 1'b0;
    io_write    = 1'b0;
    io_data_out = 8'h00;
    if (!reset && cpu_enable && is_high && !is_dma_reg) begin
      io_addr     = cpu_addr;
      io_enable   = 1'b1;
      io_write    = cpu_write;
      io_data_out = cpu_data_out;
    end
  end

  // --------------------------------------------------------------------------
  // Main bus ownership. During a transfer the source address is held for the
  // whole M-cycle; otherwise low-region CPU accesses pass straight through.
  // --------------------------------------------------------------------------
  always_comb begin
    bus_addr     = 16'h0000;
    bus_enable   = 1'b0;
    bus_write    = 1'b0;
    bus_data_out = 8'h00;
    if (active) begin
      bus_addr   = {src_hi, idx};
      bus_enable = 1'b1;
    end else if (!reset && cpu_enable && !is_high) begin
      bus_addr     = cpu_addr;
      bus_enable   = 1'b1;
      bus_write    = cpu_write;
      bus_data_out = cpu_data_out;
    end
  end

  // --------------------------------------------------------------------------
  // OAM write: the source byte has had three T-cycles to settle, so it is
  // captured from the bus in T3.
  // --------------------------------------------------------------------------
  always_comb begin
    oam_write = 1'b0;
    oam_addr  = 8'h00;
    oam_data  = 8'h00;
    if (active && t3) begin
      oam_write = 1'b1;
      oam_addr  = idx;
      oam_data  = bus_data_in;
    end
  end

  // --------------------------------------------------------------------------
  // CPU read-data mux.
  // --------------------------------------------------------------------------
  always_comb begin
    if (is_dma_reg) begin
      cpu_data_in = dma_reg;
    end else if (is_high) begin
      cpu_data_in = io_data_in;
    end else if (active) begin
      cpu_data_in = 8'hFF;
    end else begin
      cpu_data_in = bus_data_in;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_oam_dma.sv
`default_nettype none
// ============================================================================
//  Module   : tb_oam_dma
//  Purpose  : Self-checking bench for oam_dma. A transfer-level model (start
//             M-cycle, source page, register value) predicts every output on
//             every cycle; directed scenarios add literal expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_oam_dma;

  localparam int DMA_LEN = 160;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic        cpu_enable;
  logic        cpu_write;
  logic [7:0]  cpu_data_out;
  logic [7:0]  cpu_data_in;
  logic [15:0] bus_addr;
  logic        bus_enable;
  logic        bus_write;
  logic [7:0]  bus_data_out;
  logic [7:0]  bus_data_in;
  logic [15:0] io_addr;
  logic        io_enable;
  logic        io_write;
  logic [7:0]  io_data_out;
  logic [7:0]  io_data_in;
  logic [7:0]  oam_addr;
  logic        oam_write;
  logic [7:0]  oam_data;
  logic        dma_active;

  always #5 clk = ~clk;

  oam_dma #(.DMA_LEN(DMA_LEN)) dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_enable(cpu_enable), .cpu_write(cpu_write),
    .cpu_data_out(cpu_data_out), .cpu_data_in(cpu_data_in),
    .bus_addr(bus_addr), .bus_enable(bus_enable), .bus_write(bus_write),
    .bus_data_out(bus_data_out), .bus_data_in(bus_data_in),
    .io_addr(io_addr), .io_enable(io_enable), .io_write(io_write),
    .io_data_out(io_data_out), .io_data_in(io_data_in),
    .oam_addr(oam_addr), .oam_write(oam_write), .oam_data(oam_data),
    .dma_active(dma_active)
  );

  // Memory contents are pure functions of the address.
  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    return a[15:8] ^ a[7:0] ^ 8'h5A;
  endfunction
  function automatic logic [7:0] io_byte(input logic [15:0] a);
    return a[7:0] + 8'h33;
  endfunction

  assign bus_data_in = mem_byte(bus_addr);
  assign io_data_in  = io_byte(io_addr);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Transfer-level model: a transfer is just "byte k is copied in M-cycle
  // base+k" for k in 0..DMA_LEN-1; a 0xFF46 write in M-cycle n sets base=n+2.
  // --------------------------------------------------------------------------
  int         cyc   = 0;
  int         base  = -1000;
  logic [7:0] m_dma = 8'h00;
  logic [7:0] m_src = 8'h00;

  always @(posedge clk) begin
    if (reset) begin
      cyc   <= 0;
      base  <= -1000;
      m_dma <= 8'h00;
      m_src <= 8'h00;
    end else begin
      if ((cyc % 4) == 3 && cpu_enable && cpu_write && cpu_addr == 16'hFF46) begin
        m_dma <= cpu_data_out;
        m_src <= (cpu_data_out >= 8'hE0) ? cpu_data_out - 8'h20 : cpu_data_out;
        base  <= cyc / 4 + 2;
      end
      cyc <= cyc + 1;
    end
  end

  // Log of DUT OAM writes, for scenario-level literal checks.
  int         log_m[$];
  logic [15:0] log_bus[$];
  logic [7:0] log_oam[$];
  logic [7:0] log_data[$];

  task automatic clear_log();
    log_m.delete(); log_bus.delete(); log_oam.delete(); log_data.delete();
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    int          m, t, bi;
    bit          act;
    logic [15:0] e_baddr, e_iaddr;
    logic        e_ben, e_bwr, e_ien, e_iwr, e_ow;
    logic [7:0]  e_bdo, e_ido, e_oa, e_od, e_rd;

    m   = cyc / 4;
    t   = cyc % 4;
    bi  = m - base;
    act = !reset && bi >= 0 && bi < DMA_LEN;

    e_baddr = 16'h0; e_ben = 1'b0; e_bwr = 1'b0; e_bdo = 8'h0;
    if (act) begin
      e_baddr = {m_src, 8'(bi)};
      e_ben   = 1'b1;
    end else if (!reset && cpu_enable && cpu_addr < 16'hFF00) begin
      e_baddr = cpu_addr; e_ben = 1'b1; e_bwr = cpu_write; e_bdo = cpu_data_out;
    end

    e_iaddr = 16'h0; e_ien = 1'b0; e_iwr = 1'b0; e_ido = 8'h0;
    if (!reset && cpu_enable && cpu_addr >= 16'hFF00 && cpu_addr != 16'hFF46) begin
      e_iaddr = cpu_addr; e_ien = 1'b1; e_iwr = cpu_write; e_ido = cpu_data_out;
    end

    e_ow = act && t == 3;
    e_oa = e_ow ? 8'(bi) : 8'h00;
    e_od = e_ow ? mem_byte(e_baddr) : 8'h00;

    if (cpu_addr == 16'hFF46)       e_rd = m_dma;
    else if (cpu_addr >= 16'hFF00)  e_rd = io_byte(e_iaddr);
    else if (act)                   e_rd = 8'hFF;
    else                            e_rd = mem_byte(e_baddr);

    chk("dma_active",   dma_active,   act);
    chk("bus_addr",     bus_addr,     e_baddr);
    chk("bus_enable",   bus_enable,   e_ben);
    chk("bus_write",    bus_write,    e_bwr);
    chk("bus_data_out", bus_data_out, e_bdo);
    chk("io_addr",      io_addr,      e_iaddr);
    chk("io_enable",    io_enable,    e_ien);
    chk("io_write",     io_write,     e_iwr);
    chk("io_data_out",  io_data_out,  e_ido);
    chk("oam_write",    oam_write,    e_ow);
    chk("oam_addr",     oam_addr,     e_oa);
    chk("oam_data",     oam_data,     e_od);
    chk("cpu_data_in",  cpu_data_in,  e_rd);

    if (oam_write === 1'b1) begin
      log_m.push_back(m);
      log_bus.push_back(bus_addr);
      log_oam.push_back(oam_addr);
      log_data.push_back(oam_data);
    end
  end

  // One CPU M-cycle, starting in T0; outputs snapshotted in T0.
  logic [7:0]  cap_rd;
  logic        cap_io_en, cap_bus_wr, cap_active;
  logic [15:0] cap_bus_addr;

  task automatic mcycle(input logic [15:0] a, input logic en, input logic wr,
                        input logic [7:0] d);
    cpu_addr = a; cpu_enable = en; cpu_write = wr; cpu_data_out = d;
    @(negedge clk);
    cap_rd = cpu_data_in; cap_io_en = io_enable; cap_bus_wr = bus_write;
    cap_bus_addr = bus_addr; cap_active = dma_active;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic idle_m(input int k);
    for (int i = 0; i < k; i++) mcycle(16'h0000, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic idle_until(input int mc);
    while (cyc / 4 < mc) idle_m(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int sz;
    reset = 1'b1; cpu_addr = 16'h0; cpu_enable = 1'b0; cpu_write = 1'b0; cpu_data_out = 8'h0;
    @(negedge clk);
    chk("reset_dma_active", dma_active, 1'b0);
    chk("reset_oam_write",  oam_write,  1'b0);
    chk("reset_bus_enable", bus_enable, 1'b0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    mcycle(16'hFF46, 1'b1, 1'b0, 8'h00);
    chk("reset_reg_read", cap_rd, 8'h00);

    // ---- Full transfer from page 0xC1 --------------------------------------
    clear_log();
    n = cyc / 4;
    mcycle(16'hFF46, 1'b1, 1'b1, 8'hC1);
    idle_m(1);
    mcycle(16'hC000, 1'b1, 1'b0, 8'h00);            // n+2, byte 0
    chk("blocked_read", cap_rd, 8'hFF);
    chk("blocked_read_bus_addr", cap_bus_addr, 16'hC100);
    mcycle(16'hFF80, 1'b1, 1'b0, 8'h00);            // n+3
    chk("io_read_enable", cap_io_en, 1'b1);
    chk("io_read_data", cap_rd, 8'hB3);
    mcycle(16'hFE10, 1'b1, 1'b1, 8'h77);            // n+4, byte 2
    chk("blocked_write", cap_bus_wr, 1'b0);
    chk("blocked_write_bus_addr", cap_bus_addr, 16'hC102);
    idle_until(n + 162);
    mcycle(16'hC000, 1'b1, 1'b0, 8'h00);            // n+162
    chk("idle_after_xfer", cap_active, 1'b0);
    chk("idle_read", cap_rd, 8'h9A);
    mcycle(16'hFE10, 1'b1, 1'b1, 8'h77);
    chk("idle_write", cap_bus_wr, 1'b1);
    chk("idle_write_addr", cap_bus_addr, 16'hFE10);
    chk("xfer_count", log_m.size(), 160);
    chk("xfer_first_m", log_m[0], n + 2);
    chk("xfer_last_m", log_m[159], n + 161);
    chk("xfer_first_bus", log_bus[0], 16'hC100);
    chk("xfer_last_bus", log_bus[159], 16'hC19F);
    chk("xfer_last_oam", log_oam[159], 8'h9F);
    chk("xfer_data10", log_data[10], 8'h91);

    // ---- Echo page, rewrite at byte 50, reset at byte 80 -------------------
    clear_log();
    n = cyc / 4;
    mcycle(16'hFF46, 1'b1, 1'b1, 8'hE3);
    idle_m(1);
    mcycle(16'hFF46, 1'b1, 1'b0, 8'h00);            // n+2
    chk("echo_reg_read", cap_rd, 8'hE3);
    chk("echo_bus_addr", cap_bus_addr, 16'hC300);
    idle_until(n + 52);
    mcycle(16'hFF46, 1'b1, 1'b1, 8'hD0);            // byte 50 of old transfer
    idle_until(n + 134);                            // byte 80 of new transfer
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    sz = log_m.size();
    chk("restart_count", sz, 131);
    chk("old_last_m", log_m[50], n + 52);
    chk("old_last_bus", log_bus[50], 16'hC332);
    chk("restart_first_bus", log_bus[51], 16'hD000);
    chk("restart_first_m", log_m[51], n + 54);
    chk("restart_first_oam", log_oam[51], 8'h00);
    chk("pre_reset_bus", log_bus[130], 16'hD04F);
    chk("pre_reset_oam", log_oam[130], 8'h4F);
    idle_m(8);
    mcycle(16'hFF46, 1'b1, 1'b0, 8'h00);
    chk("post_reset_no_oam", log_m.size(), sz);
    chk("post_reset_reg", cap_rd, 8'h00);
    chk("post_reset_active", cap_active, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/oam_dma.md
OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 SHALL have parameter DMA_LEN, default 160, number of bytes per transfer (1..256).
REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
  clk  input  1  clock (normally 4 MHz)
  reset  input  1  synchronous reset, active high
  cpu_addr  input  16  CPU bus address
  cpu_enable  input  1  CPU bus access enable
  cpu_write  input  1  CPU bus write enable
  cpu_data_out  input  8  CPU write data
  cpu_data_in  output  8  read data returned to CPU
  bus_addr  output  16  main bus address (0x0000-0xFEFF region)
  bus_enable  output  1  main bus access enable
  bus_write  output  1  main bus write enable
  bus_data_out  output  8  main bus write data
  bus_data_in  input  8  main bus read data
  io_addr  output  16  high-region address (0xFF00-0xFFFF)
  io_enable  output  1  high-region access enable
  io_write  output  1  high-region write enable
  io_data_out  output  8  high-region write data
  io_data_in  input  8  high-region read data
  oam_addr  output  8  OAM write index
  oam_write  output  1  OAM write strobe
  oam_data  output  8  OAM write data
  dma_active  output  1  DMA owns main bus

Function
REQ-003 SHALL keep an internal 2-bit T-cycle counter, reset to 0 and incremented every clk, so phase matches the CPU (both reset together); all register updates occur on the clk edge where the counter is 3.
REQ-004 SHALL hold an 8-bit register DMA at 0xFF46; a CPU write (cpu_enable & cpu_write & cpu_addr==0xFF46) at T3 loads cpu_data_out into it and into source high byte src_hi.
REQ-005 SHALL fold src_hi values 0xE0-0xFF to value & 0xDF (echo RAM); the DMA register keeps the unfolded value.
REQ-006 SHALL implement states IDLE, START, ACTIVE; IDLE->START on the T3 edge of a 0xFF46 write; START->ACTIVE after exactly one M-cycle; ACTIVE->IDLE on the T3 edge of byte DMA_LEN-1.
REQ-007 SHALL, in ACTIVE for byte i (8-bit counter, 0 at entry), drive bus_addr={src_hi,i}, bus_enable=1, bus_write=0 for all four T-cycles, and at T3 drive oam_write=1, oam_addr=i, oam_data=bus_data_in; i increments at the T3 edge.
REQ-008 SHALL assert dma_active only in ACTIVE; START does not block the CPU.
REQ-009 SHALL route CPU accesses with cpu_addr>=0xFF00, except 0xFF46, to io_*, in every state (io_addr=cpu_addr, io_enable=cpu_enable, io_write=cpu_write, io_data_out=cpu_data_out).
REQ-010 SHALL route CPU accesses with cpu_addr<0xFF00 to bus_* when dma_active=0; when dma_active=1 such CPU writes are dropped and reads return 0xFF.
REQ-011 SHALL return on cpu_data_in, combinationally: DMA register for 0xFF46; io_data_in for other >=0xFF00; bus_data_in for <0xFF00 when not blocked; 0xFF when blocked.
REQ-012 SHALL never assert io_enable for accesses to 0xFF46.
REQ-013 SHALL deassert io_enable, bus_enable, bus_write and oam_write when no access applies; unused address/data outputs drive 0.
REQ-014 SHALL, on a 0xFF46 write in START or ACTIVE, abort the current transfer (no further OAM writes), reload src_hi, reset i to 0, and enter START at that T3 edge.
REQ-015 SHALL, when DMA_LEN byte writes complete, leave bus_* owned by the CPU from the next T0.

Reset
REQ-016 SHALL, while reset is high, clear T-cycle counter, state (IDLE), i, src_hi and DMA register to 0; all enable/strobe outputs and dma_active 0, cpu_data_in per REQ-011.
REQ-017 SHALL, on reset mid-transfer, abandon the transfer immediately with no further oam_write pulses.

Verification
REQ-018 Write 0xC1 to 0xFF46 at M-cycle n -> START in n+1; oam_write pulses at T3 of n+2..n+161 with bus_addr 0xC100..0xC19F and oam_addr 0..159; IDLE at n+162.
REQ-019 CPU read of 0xC000 during ACTIVE -> cpu_data_in=0xFF, bus_addr still DMA source; CPU read of 0xFF80 -> io_enable=1, io_data_in returned.
REQ-020 Write 0xE3 to 0xFF46 -> bus_addr starts at 0xC300; read of 0xFF46 returns 0xE3.
REQ-021 Rewrite 0xFF46=0xD0 at byte 50 -> one START M-cycle, transfer restarts at 0xD000 with oam_addr 0; no write for old byte 51.
REQ-022 Assert reset at byte 80 -> oam_write never pulses again, dma_active=0, 0xFF46 reads 0x00.
REQ-023 CPU write to 0xFE10 during ACTIVE -> bus_write stays 0; same write in IDLE -> bus_write=1, bus_addr=0xFE10.
